// File: rtl/config_loader.sv
// Configuration loader: accepts host words and serialises them LSB-first into a
// configuration shift chain, then issues a one-cycle commit pulse and a done pulse.
module config_loader #(
  parameter int WORD     = 16,
  parameter int CFG_BITS = 40,
  parameter int CW       = $clog2(CFG_BITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  input  logic [WORD-1:0] in_data,
  output logic            in_ready,
  output logic            cfg_en,
  output logic            cfg_bit,
  output logic            cset,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   bit_cnt
);

  localparam int FW = $clog2(WORD + 1);
  localparam logic [CW-1:0] LastCnt = CW'(CFG_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit, StDone} state_e;

  state_e          state_q, state_d;
  logic [WORD-1:0] buf_q, buf_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last_shift = (fill_q != '0) && (cnt_q == LastCnt);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    cfg_en   = 1'b0;
    cfg_bit  = 1'b0;
    cset     = 1'b0;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = '0;
          fill_d  = '0;
          buf_d   = '0;
        end
      end
      StLoad: begin
        if (abort) begin
          // Abort wins over any capture or final shift in the same cycle.
          state_d = StIdle;
          fill_d  = '0;
          buf_d   = '0;
        end else begin
          if (fill_q != '0) begin
            cfg_en  = 1'b1;
            cfg_bit = buf_q[0];
            buf_d   = buf_q >> 1;
            fill_d  = fill_q - FW'(1);
            cnt_d   = cnt_q + CW'(1);
          end
          // Refill when empty, or when the last buffered bit leaves this cycle,
          // unless that bit completes the chain.
          in_ready = (fill_q == '0) || ((fill_q == FW'(1)) && !last_shift);
          if (in_ready && in_valid) begin
            buf_d  = in_data;
            fill_d = FW'(WORD);
          end
          if (last_shift) begin
            // Unused upper bits of the final word are dropped here.
            state_d = StCommit;
            buf_d   = '0;
            fill_d  = '0;
          end
        end
      end
      StCommit: begin
        cset    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: scoreboard of expected serial bits plus
// cycle-accurate checks of handshake, commit and done timing.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [15:0] in_data;
  logic        in_ready, cfg_en, cfg_bit, cset, busy, done;
  logic [5:0]  bit_cnt;

  logic        start32, in_valid32;
  logic [15:0] in_data32;
  logic        in_ready32, cfg_en32, cfg_bit32, cset32, busy32, done32;
  logic [5:0]  bit_cnt32;

  config_loader #(.WORD(16), .CFG_BITS(40)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
    .cset(cset), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  config_loader #(.WORD(16), .CFG_BITS(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .abort(1'b0), .in_valid(in_valid32),
    .in_data(in_data32), .in_ready(in_ready32), .cfg_en(cfg_en32), .cfg_bit(cfg_bit32),
    .cset(cset32), .busy(busy32), .done(done32), .bit_cnt(bit_cnt32)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic [15:0] words_q[$];
  bit          exp_bits[$];
  int          stall_lo = -1;
  int          stall_hi = -2;

  logic        s_ready, s_en, s_bit, s_cset, s_done, s_busy, s_acc;
  logic [5:0]  s_cnt;
  int          s_cyc;
  int          first_en, last_en, n_en, cset_cyc, n_cset, done_cyc, n_done;
  int          acc_cyc[$];

  task automatic prep_load(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input int nbits);
    logic [15:0] w[3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    words_q.delete();
    exp_bits.delete();
    acc_cyc.delete();
    for (int i = 0; i < 3; i++) words_q.push_back(w[i]);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(w[i / 16][i % 16]);
    first_en = -1; last_en = -1; n_en = 0;
    cset_cyc = -1; n_cset = 0; done_cyc = -1; n_done = 0;
    stall_lo = -1; stall_hi = -2;
  endtask

  // One clock of the 40-bit DUT: host drives at negedge, outputs sampled 1ns before posedge.
  task automatic step();
    in_valid = (words_q.size() > 0) && !(cyc >= stall_lo && cyc <= stall_hi);
    in_data  = (words_q.size() > 0) ? words_q[0] : 16'h0;
    #4;
    s_ready = in_ready; s_en = cfg_en; s_bit = cfg_bit; s_cset = cset;
    s_done = done; s_busy = busy; s_cnt = bit_cnt; s_cyc = cyc;
    s_acc = in_valid && in_ready;
    @(posedge clk);
    @(negedge clk);
    if (s_acc) void'(words_q.pop_front());
    cyc++;
    if (s_acc) acc_cyc.push_back(s_cyc);
    if (s_en) begin
      n_en++;
      if (first_en < 0) first_en = s_cyc;
      last_en = s_cyc;
    end
    if (s_cset) begin n_cset++; cset_cyc = s_cyc; end
    if (s_done) begin n_done++; done_cyc = s_cyc; end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    start32 = 1'b0; in_valid32 = 1'b0; in_data32 = '0;
    #3;
    n_tests++;
    if ({in_ready, cfg_en, cfg_bit, cset, busy, done} !== 6'b0 || bit_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b cnt %0d want 000000 cnt 0",
               {in_ready, cfg_en, cfg_bit, cset, busy, done}, bit_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_continuous();
    prep_load(16'hA5C3, 16'h0F0F, 16'h00FF, 40);
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 46; c++) begin
      step();
      if (s_en) begin
        n_tests++;
        if (exp_bits.size() == 0 || s_bit !== exp_bits[0]) begin
          n_fail++;
          $display("FAIL cont_bit cycle %0d got %b want %b", s_cyc, s_bit,
                   (exp_bits.size() > 0) ? exp_bits[0] : 1'bx);
        end
        if (exp_bits.size() > 0) void'(exp_bits.pop_front());
      end
    end
    n_tests++;
    if (first_en != 2 || last_en != 41 || n_en != 40) begin
      n_fail++;
      $display("FAIL cont_en got %0d..%0d n=%0d want 2..41 n=40", first_en, last_en, n_en);
    end
    n_tests++;
    if (cset_cyc != 42 || n_cset != 1 || done_cyc != 43 || n_done != 1) begin
      n_fail++;
      $display("FAIL cont_cset_done got cset %0d x%0d done %0d x%0d want 42 x1 43 x1",
               cset_cyc, n_cset, done_cyc, n_done);
    end
    n_tests++;
    if (acc_cyc.size() != 3 || acc_cyc[0] != 1 || acc_cyc[1] != 17 || acc_cyc[2] != 33) begin
      n_fail++;
      $display("FAIL cont_accept got %p want '{1,17,33}", acc_cyc);
    end
    n_tests++;
    if (s_cnt !== 6'd40 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_final got cnt %0d busy %b want 40 0", s_cnt, s_busy);
    end
  endtask

  task automatic test_stall();
    prep_load(16'hA5C3, 16'h0F0F, 16'h00FF, 40);
    stall_lo = 17; stall_hi = 21;
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 52; c++) begin
      step();
      if (s_en) begin
        n_tests++;
        if (exp_bits.size() == 0 || s_bit !== exp_bits[0]) begin
          n_fail++;
          $display("FAIL stall_bit cycle %0d got %b want %b", s_cyc, s_bit,
                   (exp_bits.size() > 0) ? exp_bits[0] : 1'bx);
        end
        if (exp_bits.size() > 0) void'(exp_bits.pop_front());
      end
      if (s_cyc >= 18 && s_cyc <= 22) begin
        n_tests++;
        if (s_en !== 1'b0 || s_cnt !== 6'd16) begin
          n_fail++;
          $display("FAIL stall_hold cycle %0d got en %b cnt %0d want 0 16", s_cyc, s_en, s_cnt);
        end
      end
    end
    n_tests++;
    if (n_en != 40 || last_en != 46 || cset_cyc != 47 || done_cyc != 48) begin
      n_fail++;
      $display("FAIL stall_timing got n=%0d last %0d cset %0d done %0d want 40 46 47 48",
               n_en, last_en, cset_cyc, done_cyc);
    end
    n_tests++;
    if (acc_cyc.size() != 3 || acc_cyc[1] != 22 || acc_cyc[2] != 38) begin
      n_fail++;
      $display("FAIL stall_accept got %p want '{1,22,38}", acc_cyc);
    end
  endtask

  task automatic test_abort();
    prep_load(16'h1357, 16'h2468, 16'hFFFF, 40);
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      abort = (cyc == 22);
      step();
      abort = 1'b0;
      if (s_en && s_cyc != 22) begin
        n_tests++;
        if (exp_bits.size() == 0 || s_bit !== exp_bits[0]) begin
          n_fail++;
          $display("FAIL abort_bit cycle %0d got %b want %b", s_cyc, s_bit,
                   (exp_bits.size() > 0) ? exp_bits[0] : 1'bx);
        end
        if (exp_bits.size() > 0) void'(exp_bits.pop_front());
      end
    end
    n_tests++;
    if (s_cnt !== 6'd20) begin
      n_fail++;
      $display("FAIL abort_cnt got %0d want 20", s_cnt);
    end
    words_q.delete();
    step();
    n_tests++;
    if (s_busy !== 1'b0 || s_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle got busy %b en %b want 0 0", s_busy, s_en);
    end
    for (int c = 0; c < 10; c++) step();
    n_tests++;
    if (n_cset != 0 || n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_commit got cset %0d done %0d want 0 0", n_cset, n_done);
    end
    prep_load(16'hA5C3, 16'h0F0F, 16'h00FF, 40);
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 46; c++) begin
      step();
      if (s_cyc == 1) begin
        n_tests++;
        if (s_cnt !== 6'd0) begin
          n_fail++;
          $display("FAIL abort_restart_cnt got %0d want 0", s_cnt);
        end
      end
      if (s_en) begin
        n_tests++;
        if (exp_bits.size() == 0 || s_bit !== exp_bits[0]) begin
          n_fail++;
          $display("FAIL abort_reload_bit cycle %0d got %b", s_cyc, s_bit);
        end
        if (exp_bits.size() > 0) void'(exp_bits.pop_front());
      end
    end
    n_tests++;
    if (n_en != 40 || cset_cyc != 42 || done_cyc != 43) begin
      n_fail++;
      $display("FAIL abort_reload got n=%0d cset %0d done %0d want 40 42 43",
               n_en, cset_cyc, done_cyc);
    end
  endtask

  task automatic test_reset_mid_load();
    prep_load(16'hBEEF, 16'hCAFE, 16'h0123, 40);
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 32; c++) step();
    #1;
    n_tests++;
    if (bit_cnt !== 6'd30 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre got cnt %0d busy %b want 30 1", bit_cnt, busy);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, cfg_en, cfg_bit, cset, busy, done} !== 6'b0 || bit_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_async got %b cnt %0d want 000000 cnt 0",
               {in_ready, cfg_en, cfg_bit, cset, busy, done}, bit_cnt);
    end
    @(negedge clk);
    words_q.delete();
    rst = 1'b1;
    n_cset = 0; n_done = 0;
    for (int c = 0; c < 50; c++) step();
    n_tests++;
    if (n_cset != 0 || n_done != 0) begin
      n_fail++;
      $display("FAIL rst_no_commit got cset %0d done %0d want 0 0", n_cset, n_done);
    end
  endtask

  task automatic test_start_ignored();
    prep_load(16'h5A5A, 16'hC3C3, 16'h0F0F, 40);
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 46; c++) begin
      start = (cyc == 10 || cyc == 42);
      step();
      start = 1'b0;
      if (s_en) begin
        n_tests++;
        if (exp_bits.size() == 0 || s_bit !== exp_bits[0]) begin
          n_fail++;
          $display("FAIL busy_bit cycle %0d got %b", s_cyc, s_bit);
        end
        if (exp_bits.size() > 0) void'(exp_bits.pop_front());
      end
      if (s_cyc == 11) begin
        n_tests++;
        if (s_cnt !== 6'd9) begin
          n_fail++;
          $display("FAIL busy_cnt got %0d want 9", s_cnt);
        end
      end
      if (s_cyc == 44) begin
        n_tests++;
        if (s_busy !== 1'b0 || s_cnt !== 6'd40) begin
          n_fail++;
          $display("FAIL busy_after got busy %b cnt %0d want 0 40", s_busy, s_cnt);
        end
      end
    end
    n_tests++;
    if (n_en != 40 || cset_cyc != 42 || n_cset != 1 || done_cyc != 43) begin
      n_fail++;
      $display("FAIL busy_timing got n=%0d cset %0d x%0d done %0d want 40 42 x1 43",
               n_en, cset_cyc, n_cset, done_cyc);
    end
  endtask

  task automatic test_boundary32();
    logic [15:0] w32[$];
    bit          e32[$];
    int          acc[$];
    int          late_ready = 0;
    int          last32 = -1;
    int          cset32_cyc = -1;
    logic        r, en, b, cs, acc_now;
    w32 = '{16'h1234, 16'h5678, 16'h9ABC};
    for (int i = 0; i < 32; i++) e32.push_back(w32[i / 16][i % 16]);
    for (int c = 0; c < 40; c++) begin
      start32    = (c == 0);
      in_valid32 = (w32.size() > 0);
      in_data32  = (w32.size() > 0) ? w32[0] : 16'h0;
      #4;
      r = in_ready32; en = cfg_en32; b = cfg_bit32; cs = cset32;
      acc_now = in_valid32 && r;
      @(posedge clk);
      @(negedge clk);
      if (acc_now) begin void'(w32.pop_front()); acc.push_back(c); end
      if (c > 17 && r) late_ready++;
      if (cs) cset32_cyc = c;
      if (en) begin
        last32 = c;
        n_tests++;
        if (e32.size() == 0 || b !== e32[0]) begin
          n_fail++;
          $display("FAIL b32_bit cycle %0d got %b", c, b);
        end
        if (e32.size() > 0) void'(e32.pop_front());
      end
    end
    start32 = 1'b0; in_valid32 = 1'b0;
    n_tests++;
    if (acc.size() != 2 || acc[0] != 1 || acc[1] != 17 || late_ready != 0) begin
      n_fail++;
      $display("FAIL b32_accept got %p late_ready %0d want '{1,17} 0", acc, late_ready);
    end
    n_tests++;
    if (last32 != 33 || cset32_cyc != 34 || bit_cnt32 !== 6'd32) begin
      n_fail++;
      $display("FAIL b32_commit got last %0d cset %0d cnt %0d want 33 34 32",
               last32, cset32_cyc, bit_cnt32);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_abort();
    test_reset_mid_load();
    test_start_ignored();
    test_boundary32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD, default 16: width of each host configuration word.
REQ-002 SHALL have parameter CFG_BITS, default 40: total length of the configuration shift chain.
REQ-003 SHALL have parameter CW, default $clog2(CFG_BITS+1): width of the bit counter.
REQ-004 SHALL have port clk  input  1  clock; every register updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin a configuration load.
REQ-007 SHALL have port abort  input  1  cancel the load in progress.
REQ-008 SHALL have port in_valid  input  1  host word valid.
REQ-009 SHALL have port in_data  input  WORD  host configuration word, LSB shifted first.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 SHALL have port cfg_en  output  1  chain shift enable.
REQ-012 SHALL have port cfg_bit  output  1  serial configuration bit into the chain.
REQ-013 SHALL have port cset  output  1  commit pulse to connection blocks.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have port done  output  1  load completed.
REQ-016 SHALL have port bit_cnt  output  CW  number of bits shifted in the current load.

Function
REQ-017 SHALL implement states IDLE, LOAD, COMMIT and DONE.
REQ-018 SHALL move IDLE -> LOAD on start=1, clearing bit_cnt to 0 and emptying the word buffer.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL hold a WORD-bit shift buffer plus a fill count in the range 0..WORD.
REQ-021 SHALL drive in_ready=1 only in LOAD, and only when the fill count is 0, or when the fill count is 1 and that last bit shifts this cycle.
REQ-022 SHALL, on in_valid & in_ready, load in_data into the buffer and set the fill count to WORD.
REQ-023 SHALL make a word captured in cycle N available to shift first in cycle N+1.
REQ-024 SHALL shift in every LOAD cycle with fill count >= 1: cfg_en=1, cfg_bit=buf[0], buffer >>1, fill count -1, bit_cnt +1.
REQ-025 SHALL drive cfg_en=0 and cfg_bit=0 when no shift occurs.
REQ-026 SHALL sustain back-to-back words with no bubble: one bit per cycle while in_valid stays high.
REQ-027 SHALL, when in_valid is low and the buffer is empty, stall with cfg_en=0 and hold bit_cnt.
REQ-028 SHALL move LOAD -> COMMIT in the cycle the shift takes bit_cnt to CFG_BITS.
REQ-029 SHALL discard the unused upper bits of the final word.
REQ-030 SHALL keep in_ready=0 once bit_cnt reaches CFG_BITS.
REQ-031 SHALL, in COMMIT, assert cset=1 for exactly one cycle, then go to DONE.
REQ-032 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE.
REQ-033 SHALL hold bit_cnt at its final value until the next start.
REQ-034 SHALL, on abort=1 in LOAD, go to IDLE next cycle, empty the buffer, keep cset=0 and done=0, and not accept a word that cycle.
REQ-035 SHALL give abort priority over a simultaneous word capture or final shift.
REQ-036 SHALL ignore abort in IDLE, COMMIT and DONE.
REQ-037 SHALL drive busy=1 in LOAD, COMMIT and DONE.

Reset
REQ-038 SHALL, while rst=0, immediately force state IDLE, buffer and fill count 0, bit_cnt 0, and in_ready, cfg_en, cfg_bit, cset, busy and done all 0, independent of clk.
REQ-039 SHALL, when reset is applied mid-LOAD, leave the chain partially shifted and never issue cset for that load.

Verification
REQ-040 SHALL cover a continuous load: WORD=16, CFG_BITS=40, start at cycle 0, in_valid held with words 0xA5C3, 0x0F0F, 0x00FF -> cfg_en high cycles 2..41, cfg_bit sequence equals the 40 LSB-first bits, cset at cycle 42, done at cycle 43, words accepted at cycles 1, 17 and 33.
REQ-041 SHALL cover host stalls: in_valid low for 5 cycles between words -> cfg_en low for 5 cycles, bit sequence unchanged, cset delayed by 5 cycles.
REQ-042 SHALL cover abort: abort=1 at bit_cnt=20 -> IDLE next cycle, no cset, no done; a following start with a full load completes normally with bit_cnt=0 at its start.
REQ-043 SHALL cover reset mid-load: rst=0 asynchronously at bit_cnt=30 -> all outputs 0 before the next clk edge, and no cset after release.
REQ-044 SHALL cover start ignored while busy: start pulsed in LOAD and COMMIT -> no restart, and bit_cnt is not cleared.
REQ-045 SHALL cover a final-word boundary: CFG_BITS=32, WORD=16 -> exactly two words accepted, in_ready low after the second, cset one cycle after the 32nd shift.
